// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared symbols for the memory bus arbiter. The core's memory-access
//   states also use these codes.
//   - arb_state_t : FSM encodings ARB_IDLE / ARB_ACCESS / ARB_DONE
//   - OWN_*       : one-hot bus owner codes (bit0 = CPU, bit1 = DMA)
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  function automatic logic own_is_cpu(input logic [1:0] own);
    return own == OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Bundles the two requester ports, the RAM-side signals and the grant
//   vector of the memory bus arbiter.
//   - slave  : arbiter view (takes requests/mem_rdata, drives acks,
//              rdata, mem_* controls and grant)
//   - master : view of the surrounding requesters and RAM macro
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        grant;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output grant
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  grant
  );

endinterface

// File: rtl/mem_bus_arbiter_bus_rr_picker.sv
// bus_rr_picker
//   Combinational owner choice from the two requests.
//   Ports: cpu_req, dma_req (requests), last_owner (only with
//   ARB_ROUND_ROBIN_EN), pick (one-hot owner, OWN_NONE if no request).
//   Build option ARB_ROUND_ROBIN_EN: on a tie, pick whoever was not the
//   last owner. Without it, CPU always wins a tie.
module bus_rr_picker
  import mem_bus_arbiter_pkg::*;
(
  input  logic       cpu_req,
  input  logic       dma_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [1:0] last_owner,
`endif
  output logic [1:0] pick
);

  always_comb begin
    pick = OWN_NONE;
    if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = own_is_cpu(last_owner) ? OWN_DMA : OWN_CPU;
`else
      pick = OWN_CPU;
`endif
    end else if (cpu_req) begin
      pick = OWN_CPU;
    end else if (dma_req) begin
      pick = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-requester (CPU, DMA) controller for the shared memory bus. One
//   owner at a time; each access holds mem_en for 1+WAIT_STATES cycles,
//   then issues a one-cycle ack to the owner.
//   Ports: clk, reset (sync, active-high), bus (mem_bus_arbiter_if.slave:
//   cpu_*/dma_* request ports, mem_* RAM controls, grant).
//   Parameters: ADDR_W, DATA_W, WAIT_STATES (0..15, 4-bit counter).
//   Build option ARB_ROUND_ROBIN_EN: round-robin on ties instead of
//   fixed CPU priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  mem_bus_arbiter_if.slave bus
);

  // WAIT_STATES above 15 does not fit the counter and is not supported.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [1:0]        owner;
  logic [3:0]        wcnt;
  logic              we_lat;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] cpu_rdata_r;
  logic [DATA_W-1:0] dma_rdata_r;
  logic [1:0]        pick;
  logic              any_req;
  logic              wait_done;

  assign any_req   = bus.cpu_req | bus.dma_req;
  assign wait_done = (wcnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_owner;

  bus_rr_picker u_picker (
    .cpu_req    (bus.cpu_req),
    .dma_req    (bus.dma_req),
    .last_owner (last_owner),
    .pick       (pick)
  );
`else
  bus_rr_picker u_picker (
    .cpu_req (bus.cpu_req),
    .dma_req (bus.dma_req),
    .pick    (pick)
  );
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (any_req)   state_nxt = ARB_ACCESS;
      ARB_ACCESS: if (wait_done) state_nxt = ARB_DONE;
      ARB_DONE:                  state_nxt = ARB_IDLE;
      default:                   state_nxt = ARB_IDLE;
    endcase
  end

  // ---- owner, wait counter, latched access and read-data registers ----
  // A reset mid-access drops the transfer; no ack follows because the
  // FSM never reaches DONE for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner       <= OWN_NONE;
      wcnt        <= 4'd0;
      we_lat      <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      cpu_rdata_r <= '0;
      dma_rdata_r <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner  <= OWN_DMA;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            owner <= pick;
            wcnt  <= WAIT_INIT;
            if (own_is_cpu(pick)) begin
              we_lat  <= bus.cpu_we;
              addr_r  <= bus.cpu_addr;
              wdata_r <= bus.cpu_wdata;
            end else begin
              we_lat  <= bus.dma_we;
              addr_r  <= bus.dma_addr;
              wdata_r <= bus.dma_wdata;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= pick;
`endif
          end
        end
        ARB_ACCESS: begin
          if (!wait_done) begin
            wcnt <= wcnt - 4'd1;
          end else if (!we_lat) begin
            if (own_is_cpu(owner)) cpu_rdata_r <= bus.mem_rdata;
            else                   dma_rdata_r <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- output decode ----
  assign bus.mem_en    = (state == ARB_ACCESS);
  assign bus.mem_we    = (state == ARB_ACCESS) & we_lat;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.grant     = (state == ARB_IDLE) ? OWN_NONE : owner;
  assign bus.cpu_ack   = (state == ARB_DONE) & (owner == OWN_CPU);
  assign bus.dma_ack   = (state == ARB_DONE) & (owner == OWN_DMA);
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.dma_rdata = dma_rdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter with WAIT_STATES=1. A RAM
//   model answers the bus; every expected transaction is queued in
//   service order and checked by a monitor as the DUT executes it.
//   Honours ARB_ROUND_ROBIN_EN for the expected tie-break order.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int WS     = 1;

  logic clk = 1'b0;
  logic reset;
  logic init_ram;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] own;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t sb[$];
  txn_t mon_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] def_byte(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  // RAM model
  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [1:0] last_own;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 256; i++) ram[i] <= def_byte(8'(i));
    end else if (bus.mem_en && bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = bus.mem_en ? ram[bus.mem_addr] : 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares bus activity against the head of the scoreboard.
  int         en_cnt     = 0;
  logic [7:0] exp_cpu_rd = 8'h00;
  logic [7:0] exp_dma_rd = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      en_cnt     = 0;
      exp_cpu_rd = 8'h00;
      exp_dma_rd = 8'h00;
    end else begin
      check("we_without_en", {31'd0, bus.mem_we & ~bus.mem_en}, 32'd0);
      if (bus.mem_en) begin
        en_cnt++;
        if (sb.size() == 0) begin
          check("spurious_mem_en", 32'd1, 32'd0);
        end else begin
          check("mem_addr", {24'd0, bus.mem_addr}, {24'd0, sb[0].addr});
          check("mem_we", {31'd0, bus.mem_we}, {31'd0, sb[0].we});
          check("grant_access", {30'd0, bus.grant}, {30'd0, sb[0].own});
          if (sb[0].we) check("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, sb[0].wdata});
        end
      end
      if (bus.cpu_ack || bus.dma_ack) begin
        if (sb.size() == 0) begin
          check("spurious_ack", {30'd0, bus.dma_ack, bus.cpu_ack}, 32'd0);
        end else begin
          mon_t = sb.pop_front();
          check("ack_owner", {30'd0, bus.dma_ack, bus.cpu_ack}, {30'd0, mon_t.own});
          check("grant_done", {30'd0, bus.grant}, {30'd0, mon_t.own});
          check("en_cycles", en_cnt, WS + 1);
          if (!mon_t.we) begin
            if (mon_t.own == OWN_CPU) exp_cpu_rd = mon_t.rdata;
            else                      exp_dma_rd = mon_t.rdata;
          end
          check("cpu_rdata", {24'd0, bus.cpu_rdata}, {24'd0, exp_cpu_rd});
          check("dma_rdata", {24'd0, bus.dma_rdata}, {24'd0, exp_dma_rd});
        end
        en_cnt = 0;
      end else if (!bus.mem_en) begin
        check("grant_idle", {30'd0, bus.grant}, 32'd0);
      end
    end
  end

  // Queue an expected transaction in the order the arbiter should serve it.
  task automatic push(input logic [1:0] own, input logic we, input logic [7:0] addr,
                      input logic [7:0] wdata);
    txn_t t;
    t.own   = own;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = we ? 8'h00 : ref_mem[addr];
    if (we) ref_mem[addr] = wdata;
    last_own = own;
    sb.push_back(t);
  endtask

  task automatic drive(input logic is_dma, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata);
    if (is_dma) begin
      bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end
  endtask

  task automatic release_req(input logic is_dma);
    if (is_dma) bus.dma_req = 1'b0;
    else        bus.cpu_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic is_dma, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (is_dma ? bus.dma_ack : bus.cpu_ack) begin
        at_cyc = cyc;
        return;
      end
    end
    check(is_dma ? "dma_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_en();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_en) return;
    end
    check("mem_en_timeout", 32'd0, 32'd1);
  endtask

  // Both requesters hold req back-to-back; CPU reads, DMA writes.
  task automatic run_both();
    logic [7:0] cpu_a [2];
    logic [7:0] dma_a [2];
    logic [7:0] dma_d [2];
    int rem_c, rem_d;
    logic [1:0] w;
    cpu_a[0] = 8'h10; cpu_a[1] = 8'h20;
    dma_a[0] = 8'h50; dma_a[1] = 8'h51;
    dma_d[0] = 8'h11; dma_d[1] = 8'h22;
    rem_c = 2; rem_d = 2;
    while (rem_c + rem_d > 0) begin
      if (rem_c > 0 && rem_d > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        w = (last_own == OWN_CPU) ? OWN_DMA : OWN_CPU;
`else
        w = OWN_CPU;
`endif
      end else begin
        w = (rem_c > 0) ? OWN_CPU : OWN_DMA;
      end
      if (w == OWN_CPU) begin
        push(OWN_CPU, 1'b0, cpu_a[2-rem_c], 8'h00);
        rem_c--;
      end else begin
        push(OWN_DMA, 1'b1, dma_a[2-rem_d], dma_d[2-rem_d]);
        rem_d--;
      end
    end
    fork
      begin
        int a;
        for (int i = 0; i < 2; i++) begin
          drive(1'b0, 1'b0, cpu_a[i], 8'h00);
          wait_ack(1'b0, a);
        end
        release_req(1'b0);
      end
      begin
        int a;
        for (int j = 0; j < 2; j++) begin
          drive(1'b1, 1'b1, dma_a[j], dma_d[j]);
          wait_ack(1'b1, a);
        end
        release_req(1'b1);
      end
    join
  endtask

  // DMA retargets its address while the CPU owns the bus.
  task automatic run_late_addr();
    push(OWN_CPU, 1'b0, 8'h10, 8'h00);
    push(OWN_DMA, 1'b0, 8'h51, 8'h00);
    fork
      begin
        int a;
        drive(1'b0, 1'b0, 8'h10, 8'h00);
        wait_ack(1'b0, a);
        release_req(1'b0);
      end
      begin
        int a;
        wait_en();
        drive(1'b1, 1'b0, 8'h50, 8'h00);
        idle(1);
        drive(1'b1, 1'b0, 8'h51, 8'h00);
        wait_ack(1'b1, a);
        check("late_addr_rdata", {24'd0, bus.dma_rdata}, 32'h22);
        release_req(1'b1);
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, a, a1, a2;
    reset    = 1'b1;
    init_ram = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = def_byte(8'(i));
    last_own = OWN_DMA;
    idle(2);
    init_ram = 1'b0;

    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_grant", {30'd0, bus.grant}, 32'd0);
    check("rst_acks", {30'd0, bus.dma_ack, bus.cpu_ack}, 32'd0);
    check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    check("rst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
    check("rst_dma_rdata", {24'd0, bus.dma_rdata}, 32'd0);
    reset = 1'b0;

    // CPU read of 0x10
    c = cyc;
    push(OWN_CPU, 1'b0, 8'h10, 8'h00);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    wait_ack(1'b0, a);
    check("read_latency", a - c, 2 + WS);
    check("read_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
    release_req(1'b0);
    idle(1);

    // DMA write then CPU read-back
    push(OWN_DMA, 1'b1, 8'h20, 8'h3C);
    drive(1'b1, 1'b1, 8'h20, 8'h3C);
    wait_ack(1'b1, a);
    check("write_keeps_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
    release_req(1'b1);
    idle(1);
    push(OWN_CPU, 1'b0, 8'h20, 8'h00);
    drive(1'b0, 1'b0, 8'h20, 8'h00);
    wait_ack(1'b0, a);
    check("readback", {24'd0, bus.cpu_rdata}, 32'h3C);
    release_req(1'b0);
    idle(1);

    // Contending requesters
    run_both();
    idle(1);

    // Reset during a DMA access
    push(OWN_DMA, 1'b0, 8'h20, 8'h00);
    drive(1'b1, 1'b0, 8'h20, 8'h00);
    wait_en();
    reset = 1'b1;
    idle(1);
    check("midrst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("midrst_grant", {30'd0, bus.grant}, 32'd0);
    check("midrst_dma_ack", {31'd0, bus.dma_ack}, 32'd0);
    check("midrst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("midrst_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'd0);
    sb.delete();
    last_own = OWN_DMA;
    reset = 1'b0;
    c = cyc;
    push(OWN_DMA, 1'b0, 8'h20, 8'h00);
    wait_ack(1'b1, a);
    check("midrst_relatency", a - c, 2 + WS);
    check("midrst_dma_rdata", {24'd0, bus.dma_rdata}, 32'h3C);
    release_req(1'b1);
    idle(1);

    // CPU back-to-back reads with req held
    push(OWN_CPU, 1'b0, 8'h00, 8'h00);
    push(OWN_CPU, 1'b0, 8'h01, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    wait_ack(1'b0, a1);
    check("b2b_rd0", {24'd0, bus.cpu_rdata}, 32'h5A);
    drive(1'b0, 1'b0, 8'h01, 8'h00);
    wait_ack(1'b0, a2);
    check("b2b_rd1", {24'd0, bus.cpu_rdata}, 32'h5B);
    check("b2b_spacing", a2 - a1, 3 + WS);
    release_req(1'b0);
    idle(1);

    // Non-owner address change
    run_late_addr();
    idle(3);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester controller for the single shared 8-bit memory bus. The CPU core's fetch/load/store/stack accesses and a DMA/program-loader port each drive a request. The block grants one owner at a time, sequences the access through a configurable number of memory wait states, and returns read data with a one-cycle acknowledge. It sits between the core's memory-access states, the DMA port and the RAM macro.

## Interface
Parameters:
- `ADDR_W`, 8, address width
- `DATA_W`, 8, data width
- `WAIT_STATES`, 0, extra cycles `mem_en` is held per access (0–15)

Ports:
- `clk`  in  1  single clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`
- `cpu_req`, `dma_req`  in  1  access request; held until ack
- `cpu_we`, `dma_we`  in  1  1 = write, 0 = read; stable while req high
- `cpu_addr`, `dma_addr`  in  ADDR_W  access address; stable while req high
- `cpu_wdata`, `dma_wdata`  in  DATA_W  write data; stable while req high
- `cpu_ack`, `dma_ack`  out  1  one-cycle completion pulse to the owner
- `cpu_rdata`, `dma_rdata`  out  DATA_W  registered read data; updated only by that requester's completed reads
- `mem_en`  out  1  memory select
- `mem_we`  out  1  memory write strobe (only while `mem_en`)
- `mem_addr`  out  ADDR_W  latched address
- `mem_wdata`  out  DATA_W  latched write data
- `mem_rdata`  in  DATA_W  memory read data, valid while `mem_en`
- `grant`  out  2  one-hot owner: bit0 = CPU, bit1 = DMA; 0 when idle

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any request is sampled high, pick the owner (see Configuration). Latch the owner's addr/we/wdata into the `mem_*` registers, load wait counter with WAIT_STATES, go to ACCESS.
- ACCESS: `mem_en`=1, `mem_we`=latched we, `grant` = owner.
  - Counter nonzero: decrement, stay in ACCESS.
  - Counter zero: on a read, capture `mem_rdata` into the owner's rdata register; go to DONE.
- DONE: `mem_en`=0, owner's ack=1, `grant` still = owner; go to IDLE unconditionally.
- A requester deasserts req in the cycle after its ack, or keeps it high with new addr/we/wdata for a back-to-back access. A req seen in IDLE is always a new transaction.
- Changes to a non-owner's inputs during an access are ignored. Its req stays pending and is served at the next IDLE.
- Reset (including mid-access): state IDLE, `mem_en`/`mem_we`/`grant`/both acks = 0, `mem_addr`/`mem_wdata`/both rdata = 0, last-owner = DMA. The in-flight access is dropped; no ack is ever issued for it.
- The wait counter is 4 bits. WAIT_STATES > 15 is illegal.

## Timing
- Request first sampled high at edge k: ACCESS occupies cycles k+1 … k+1+WAIT_STATES; ack is high in cycle k+2+WAIT_STATES.
- Latency req→ack = 2+WAIT_STATES cycles. Bus occupancy = 3+WAIT_STATES cycles per access, with no overlap between accesses.
- `cpu_rdata`/`dma_rdata` are valid in the ack cycle and hold their value until that requester's next completed read.
- `mem_addr`/`mem_wdata` are registered outputs, stable for the whole ACCESS phase.
- Ack is exactly one cycle wide and goes only to the owner. At most one ack is high in any cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, grant the requester that was not the last owner. Last-owner updates at each transition into ACCESS.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, CPU always wins. No last-owner register; DMA can starve under continuous CPU requests.
- Single-request behaviour is identical in both builds.

## Structure
- Shared symbols header/package holds:
  - state encodings `ARB_IDLE`, `ARB_ACCESS`, `ARB_DONE`
  - owner encodings `OWN_CPU` = 2'b01, `OWN_DMA` = 2'b10
- The core's memory-access states reference these owner codes.
- One sub-module: `bus_rr_picker`, a combinational choice of owner from the two reqs and last-owner. Under fixed priority it reduces to a CPU-first pick.
- The FSM, wait counter and data/address registers stay in the top module.

## Test plan
- WAIT_STATES=1, CPU read of addr 0x10 (memory holds 0xA5), req at edge 0 → `mem_en` high in cycles 1–2, `cpu_ack` high in cycle 3, `cpu_rdata`=0xA5, `grant`=01 in cycles 1–3.
- DMA write of 0x3C to 0x20 → `mem_we`=1 for the whole ACCESS phase, `dma_ack` pulses once, a subsequent CPU read of 0x20 returns 0x3C, `cpu_rdata` unchanged by the write.
- Both reqs held continuously with `ARB_ROUND_ROBIN_EN` → grants alternate CPU, DMA, CPU, DMA; without the macro → all grants go to CPU.
- Reset asserted during a DMA access's ACCESS cycle → next cycle `mem_en`=0, `grant`=0, no `dma_ack`; DMA req still high → re-served from IDLE with full latency.
- WAIT_STATES=0, CPU back-to-back reads of 0x00 then 0x01 with req held → acks 3 cycles apart, rdata updates at each ack.
- DMA changes addr while the CPU owns the bus → `mem_addr` stays at the CPU address until DONE; DMA is then served with its current addr.
